// File: rtl/gsr_sequencer.sv
// gsr_sequencer: qualifies clock lock, then drives the device GSR net low for a
// minimum width before releasing the design into RUN; supports soft-reset requests.
module gsr_sequencer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned LOCK_CYCLES   = 8,
    parameter int unsigned ASSERT_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOCK,
    input  logic       REQ,
    output logic       GSRN,
    output logic       RDY,
    output logic [7:0] RST_CNT
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [SYNC_STAGES-1:0] req_sync_q;
    logic                   req_prev_q;
    logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]       rst_cnt_q, rst_cnt_d;
    logic                   gsrn_q, gsrn_d;
    logic                   rdy_q, rdy_d;

    logic                   lock_s;
    logic                   req_s;
    logic                   req_rise;
    logic [CNT_W-1:0]       rst_cnt_inc;

    assign lock_s   = lock_sync_q[SYNC_STAGES-1];
    assign req_s    = req_sync_q[SYNC_STAGES-1];
    assign req_rise = req_s & ~req_prev_q;

    // Synchronizers for the asynchronous LOCK/REQ inputs plus REQ edge history
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lock_sync_q <= '0;
            req_sync_q  <= '0;
            req_prev_q  <= 1'b0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], LOCK};
            req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], REQ};
            req_prev_q  <= req_s;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= WAIT_LOCK;
            lock_cnt_q <= '0;
            hold_cnt_q <= '0;
            rst_cnt_q  <= '0;
            gsrn_q     <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            gsrn_q     <= gsrn_d;
            rdy_q      <= rdy_d;
        end
    end

    // Next-state logic; lock loss takes priority over a soft-reset request
    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        rst_cnt_d   = rst_cnt_q;
        rst_cnt_inc = (rst_cnt_q == CNT_MAX) ? rst_cnt_q : rst_cnt_q + CNT_W'(1);

        unique case (state_q)
            WAIT_LOCK: begin
                if (!lock_s) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = HOLD;
                    lock_cnt_d = '0;
                    hold_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    lock_cnt_d = '0;
                    hold_cnt_d = '0;
                end else if (req_rise) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    lock_cnt_d = '0;
                    rst_cnt_d  = rst_cnt_inc;
                end else if (req_rise) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                    rst_cnt_d  = rst_cnt_inc;
                end
            end
            default: begin
                state_d    = WAIT_LOCK;
                lock_cnt_d = '0;
                hold_cnt_d = '0;
            end
        endcase

        // Outputs follow the next state so they change on the transition edge
        gsrn_d = (state_d == RUN);
        rdy_d  = (state_d == RUN);
    end

    assign GSRN    = gsrn_q;
    assign RDY     = rdy_q;
    assign RST_CNT = rst_cnt_q;

endmodule

// File: tb/tb_gsr_sequencer.sv
// Testbench for gsr_sequencer: directed scenarios plus randomized run against a
// countdown/streak reference model.
module tb_gsr_sequencer;

    localparam int SYNC_STAGES   = 2;
    localparam int LOCK_CYCLES   = 8;
    localparam int ASSERT_CYCLES = 16;
    localparam int M_WAIT = 0;
    localparam int M_HOLD = 1;
    localparam int M_RUN  = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       LOCK;
    logic       REQ;
    logic       GSRN;
    logic       RDY;
    logic [7:0] RST_CNT;
    bit         clk_en = 1'b1;

    int checks = 0;
    int passed = 0;

    // Reference model: streak of qualified lock cycles, remaining low time, exit count
    int m_mode;
    int m_streak;
    int m_left;
    int m_cnt;
    bit m_lp [SYNC_STAGES];
    bit m_rp [SYNC_STAGES];
    bit m_rprev;

    gsr_sequencer #(
        .SYNC_STAGES  (SYNC_STAGES),
        .LOCK_CYCLES  (LOCK_CYCLES),
        .ASSERT_CYCLES(ASSERT_CYCLES)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .LOCK   (LOCK),
        .REQ    (REQ),
        .GSRN   (GSRN),
        .RDY    (RDY),
        .RST_CNT(RST_CNT)
    );

    // Gated clock so the async reset can be exercised with CLK stopped
    always begin
        #5;
        if (clk_en) CLK = ~CLK;
    end

    function automatic void model_reset();
        m_mode   = M_WAIT;
        m_streak = 0;
        m_left   = 0;
        m_cnt    = 0;
        m_rprev  = 1'b0;
        for (int i = 0; i < SYNC_STAGES; i++) begin
            m_lp[i] = 1'b0;
            m_rp[i] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        bit ls;
        bit rr;
        if (RST) begin
            model_reset();
            return;
        end
        ls = m_lp[SYNC_STAGES-1];
        rr = m_rp[SYNC_STAGES-1] && !m_rprev;
        if (m_mode == M_WAIT) begin
            if (ls) begin
                m_streak++;
                if (m_streak == LOCK_CYCLES) begin
                    m_mode = M_HOLD;
                    m_left = ASSERT_CYCLES;
                end
            end else begin
                m_streak = 0;
            end
        end else if (m_mode == M_HOLD) begin
            if (!ls) begin
                m_mode   = M_WAIT;
                m_streak = 0;
            end else if (rr) begin
                m_left = ASSERT_CYCLES;
            end else begin
                m_left--;
                if (m_left == 0) m_mode = M_RUN;
            end
        end else begin
            if (!ls || rr) begin
                if (m_cnt < 255) m_cnt++;
                m_mode   = ls ? M_HOLD : M_WAIT;
                m_left   = ASSERT_CYCLES;
                m_streak = 0;
            end
        end
        m_rprev = m_rp[SYNC_STAGES-1];
        for (int i = SYNC_STAGES - 1; i > 0; i--) begin
            m_lp[i] = m_lp[i-1];
            m_rp[i] = m_rp[i-1];
        end
        m_lp[0] = LOCK;
        m_rp[0] = REQ;
    endfunction

    // One clock: model advances on the rising edge, caller samples at the falling edge
    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST  = 1'b1;
        LOCK = 1'b0;
        REQ  = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic reach_run();
        do_reset();
        LOCK = 1'b1;
        repeat (26) tick();
    endtask

    task automatic test_reset();
        RST  = 1'b1;
        LOCK = 1'($urandom_range(0, 1));
        REQ  = 1'($urandom_range(0, 1));
        repeat (3) tick();
        LOCK = 1'b1;
        repeat (2) tick();
        checks++;
        if (GSRN !== 1'b0) $display("FAIL reset_gsrn: got %b want 0", GSRN); else passed++;
        checks++;
        if (RDY !== 1'b0) $display("FAIL reset_rdy: got %b want 0", RDY); else passed++;
        checks++;
        if (RST_CNT !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", RST_CNT); else passed++;
        RST = 1'b0;
        REQ = 1'b0;
    endtask

    task automatic test_powerup();
        do_reset();
        LOCK = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            tick();
            checks++;
            if (GSRN !== (e == 26)) $display("FAIL powerup_gsrn edge %0d: got %b want %b", e, GSRN, (e == 26));
            else passed++;
        end
        checks++;
        if (RDY !== 1'b1) $display("FAIL powerup_rdy: got %b want 1", RDY); else passed++;
        checks++;
        if (RST_CNT !== 8'd0) $display("FAIL powerup_cnt: got %0d want 0", RST_CNT); else passed++;
    endtask

    // LOCK low at input edges 6..8 hits the FSM while five cycles are already counted
    task automatic test_lock_flap();
        do_reset();
        LOCK = 1'b1;
        for (int e = 1; e <= 36; e++) begin
            tick();
            LOCK = !((e + 1) >= 6 && (e + 1) <= 8);
            if (e == 26 || e == 33) begin
                checks++;
                if (GSRN !== 1'b0) $display("FAIL flap_gsrn_early edge %0d: got %b want 0", e, GSRN); else passed++;
            end
            if (e == 34) begin
                checks++;
                if (GSRN !== 1'b1) $display("FAIL flap_gsrn_rise edge 34: got %b want 1", GSRN); else passed++;
            end
        end
    endtask

    task automatic test_soft_reset();
        reach_run();
        REQ = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            REQ = ((e + 1) <= 4);
            if (e == 2) begin
                checks++;
                if (GSRN !== 1'b1) $display("FAIL soft_still_run: got %b want 1", GSRN); else passed++;
            end
            if (e == 3) begin
                checks++;
                if (GSRN !== 1'b0 || RDY !== 1'b0)
                    $display("FAIL soft_drop: got gsrn=%b rdy=%b want 0 0", GSRN, RDY);
                else passed++;
                checks++;
                if (RST_CNT !== 8'd1) $display("FAIL soft_cnt: got %0d want 1", RST_CNT); else passed++;
            end
            if (e == 18) begin
                checks++;
                if (GSRN !== 1'b0) $display("FAIL soft_low_width: got %b want 0", GSRN); else passed++;
            end
            if (e == 19) begin
                checks++;
                if (GSRN !== 1'b1 || RDY !== 1'b1)
                    $display("FAIL soft_release: got gsrn=%b rdy=%b want 1 1", GSRN, RDY);
                else passed++;
            end
        end
    endtask

    // Second REQ edge reaches the FSM at hold_cnt=10, then REQ stays high
    task automatic test_stretch();
        reach_run();
        REQ = 1'b1;
        for (int e = 1; e <= 34; e++) begin
            tick();
            REQ = ((e + 1) >= 12);
            if (e == 20 || e == 29) begin
                checks++;
                if (GSRN !== 1'b0) $display("FAIL stretch_low edge %0d: got %b want 0", e, GSRN); else passed++;
            end
            if (e == 30 || e == 34) begin
                checks++;
                if (GSRN !== 1'b1) $display("FAIL stretch_release edge %0d: got %b want 1", e, GSRN); else passed++;
            end
        end
        checks++;
        if (RST_CNT !== 8'd1) $display("FAIL stretch_cnt: got %0d want 1", RST_CNT); else passed++;
        REQ = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_collision();
        reach_run();
        LOCK = 1'b0;
        REQ  = 1'b1;
        for (int e = 1; e <= 27; e++) begin
            tick();
            LOCK = 1'b1;
            REQ  = 1'b0;
            if (e == 3) begin
                checks++;
                if (RST_CNT !== 8'd1) $display("FAIL collide_cnt: got %0d want 1", RST_CNT); else passed++;
            end
            if (e == 19 || e == 26) begin
                checks++;
                if (GSRN !== 1'b0) $display("FAIL collide_requal edge %0d: got %b want 0", e, GSRN); else passed++;
            end
            if (e == 27) begin
                checks++;
                if (GSRN !== 1'b1) $display("FAIL collide_release: got %b want 1", GSRN); else passed++;
            end
        end
    endtask

    task automatic test_async_reset();
        reach_run();
        REQ = 1'b1;
        tick();
        REQ = 1'b0;
        repeat (7) tick();
        clk_en = 1'b0;
        #20;
        RST = 1'b1;
        #1;
        checks++;
        if (GSRN !== 1'b0 || RDY !== 1'b0 || RST_CNT !== 8'd0)
            $display("FAIL async_reset: got gsrn=%b rdy=%b cnt=%0d want 0 0 0", GSRN, RDY, RST_CNT);
        else passed++;
        model_reset();
        #20;
        RST    = 1'b0;
        clk_en = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            tick();
            if (e == 25 || e == 26) begin
                checks++;
                if (GSRN !== (e == 26)) $display("FAIL async_restart edge %0d: got %b want %b", e, GSRN, (e == 26));
                else passed++;
            end
        end
    endtask

    task automatic test_saturation();
        reach_run();
        for (int i = 0; i < 300; i++) begin
            REQ = 1'b1;
            tick();
            REQ = 1'b0;
            repeat (19) tick();
            if (i == 99) begin
                checks++;
                if (RST_CNT !== 8'd100) $display("FAIL sat_mid: got %0d want 100", RST_CNT); else passed++;
            end
        end
        checks++;
        if (RST_CNT !== 8'd255) $display("FAIL sat_final: got %0d want 255", RST_CNT); else passed++;
        checks++;
        if (GSRN !== 1'b1) $display("FAIL sat_run: got %b want 1", GSRN); else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            LOCK = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 99) < 10) REQ = ~REQ;
            RST = ($urandom_range(0, 999) == 0);
            tick();
            checks++;
            if (GSRN !== (m_mode == M_RUN)) $display("FAIL rand_gsrn cyc %0d: got %b want %b", c, GSRN, (m_mode == M_RUN));
            else passed++;
            checks++;
            if (RDY !== (m_mode == M_RUN)) $display("FAIL rand_rdy cyc %0d: got %b want %b", c, RDY, (m_mode == M_RUN));
            else passed++;
            checks++;
            if (RST_CNT !== 8'(m_cnt)) $display("FAIL rand_cnt cyc %0d: got %0d want %0d", c, RST_CNT, m_cnt);
            else passed++;
        end
        RST = 1'b0;
        REQ = 1'b0;
    endtask

    initial begin
        RST  = 1'b1;
        LOCK = 1'b0;
        REQ  = 1'b0;
        model_reset();
        @(negedge CLK);
        test_reset();
        test_powerup();
        test_lock_flap();
        test_soft_reset();
        test_stretch();
        test_collision();
        test_async_reset();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
